id_ex_elastic_reg: RTL and testbench
====================================

Name: id_ex_elastic_reg

Overview:
Parametrised ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer, flush and bubble insertion. Sits between the decode stage (register file and control unit outputs) and the execute stage. Lets EX back-pressure ID without a combinational ready path. Splits the packed control word into WB/MEM/EX groups as the single-cycle register does.

Parameters:
DATA_W, 32, width of RD1/RD2/Ext_Immed
REG_W, 5, register-address width (Rs/Rt/Rd)
SHAMT_W, 5, shift-amount width
FUNCT_W, 6, function-field width
WB_W, 2, WB control group width {RegWrite, MemtoReg}
MEM_W, 2, MEM control group width {MemRead, MemWrite}
EX_W, 4, EX control group width {RegDst, ALUOp, ALUSrc}
CNT_W, 16, perf counter width (optional feature only)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous reset, active-low
In_Valid  in  1  ID presents a valid instruction
In_Ready  out  1  block can accept (registered)
Flush  in  1  squash all held and incoming entries
Rs_ID, Rt_ID, Rd_ID  in  REG_W each  register addresses
Shamt_ID  in  SHAMT_W  shift amount
Funct_ID  in  FUNCT_W  function field
Ctrl_ID  in  EX_W+MEM_W+WB_W  packed {EX, MEM, WB}, WB in LSBs
RD1_ID, RD2_ID, Ext_Immed_ID  in  DATA_W each  operands
Out_Valid  out  1  EX-side entry valid
Out_Ready  in  1  EX consumes entry this cycle
WB_EX  out  WB_W ; MEM_EX  out  MEM_W ; EX_EX  out  EX_W  control groups
Rs_EX, Rt_EX, Rd_EX  out  REG_W ; Shamt_EX  out  SHAMT_W ; Funct_EX  out  FUNCT_W
RD1_EX, RD2_EX, Ext_Immed_EX  out  DATA_W

Behaviour:
- Reset (Rst=0 at posedge): all outputs 0, both entries invalid, In_Ready=0 during reset, 1 on first cycle after release.
- Accept = In_Valid & In_Ready; Consume = Out_Valid & Out_Ready. Latency: accepted entry visible on outputs next cycle.
- States: EMPTY (no entry), MAIN (output entry only), SKID (output + skid entry).
- EMPTY: Accept -> MAIN.
- MAIN: Accept & !Consume -> SKID (new entry to skid); Accept & Consume -> MAIN (new entry to output); Consume only -> EMPTY; neither -> hold.
- SKID: In_Ready=0; Consume -> MAIN, skid moves to output next cycle; else hold.
- In_Ready = (next state != SKID), registered; never depends combinationally on Out_Ready.
- Ordering strictly FIFO; no entry dropped or duplicated.
- Flush (priority over all): next state EMPTY, incoming entry discarded even if Accept, In_Ready=1 next cycle.
- Bubble: whenever Out_Valid=0, WB_EX/MEM_EX/EX_EX driven 0; data outputs hold last value.
- Stable outputs: while Out_Valid=1 & Out_Ready=0, all outputs unchanged.
- Control split: WB_EX=Ctrl[WB_W-1:0], MEM_EX=next MEM_W bits, EX_EX=top EX_W bits.

Optional Feature:
PIPE_PERF_CNT_EN: adds outputs Stall_Cnt and Flush_Cnt (CNT_W each). Stall_Cnt increments each cycle Out_Valid=1 & Out_Ready=0. Flush_Cnt increments each cycle Flush=1 with at least one valid entry held. Both saturate at all-ones and clear on reset. Without the macro, neither port nor its logic exists.

Test Plan:
- Reset: Rst=0 two cycles with In_Valid=1 -> all outputs 0, Out_Valid=0, In_Ready=0; after release In_Ready=1.
- Streaming: Out_Ready=1, accept RD1_ID=1..8 on consecutive cycles -> RD1_EX=1..8 one cycle later, Out_Valid continuous, In_Ready stays 1.
- Back-pressure: Out_Ready=0 after entry A=0xA; accept B=0xB -> In_Ready=0, RD1_EX holds 0xA; Out_Ready=1 -> 0xA then 0xB, no loss.
- Flush in SKID state with In_Valid=1, Ctrl_ID=8'hFF -> next cycle Out_Valid=0, WB/MEM/EX=0, In_Ready=1; flushed and incoming entries never appear.
- Control split: Ctrl_ID=8'b1011_01_10 -> EX_EX=4'b1011, MEM_EX=2'b01, WB_EX=2'b10.
- With PIPE_PERF_CNT_EN: hold Out_Ready=0 for 5 cycles with valid entry, then Flush -> Stall_Cnt=5, Flush_Cnt=1.

Source files
------------

// File: rtl/id_ex_elastic_reg.sv
// -----------------------------------------------------------------------------
// id_ex_elastic_reg
//   ID/EX pipeline register with a valid/ready handshake and a 2-entry skid
//   buffer. EX can back-pressure ID without any combinational path from
//   Out_Ready to In_Ready. Supports flush (squashes held and incoming
//   entries) and bubble insertion (control groups forced to 0 when no valid
//   entry is presented). The packed control word is split into WB/MEM/EX
//   groups on the way out.
//
//   Optional feature macro: PIPE_PERF_CNT_EN
//     When defined, adds the CNT_W parameter and the Stall_Cnt / Flush_Cnt
//     saturating performance counters.
//
// Ports
//   Clk, Rst                 clock (rising edge), synchronous active-low reset
//   In_Valid / In_Ready      ID-side handshake (In_Ready is registered)
//   Flush                    squash all entries, highest priority
//   Rs_ID..Ext_Immed_ID      decode-stage fields, Ctrl_ID packed {EX,MEM,WB}
//   Out_Valid / Out_Ready    EX-side handshake
//   WB_EX, MEM_EX, EX_EX     control groups (0 while Out_Valid=0)
//   Rs_EX..Ext_Immed_EX      data fields (hold last value while empty)
//   Stall_Cnt, Flush_Cnt     perf counters (PIPE_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module id_ex_elastic_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int FUNCT_W = 6,
    parameter int WB_W    = 2,
    parameter int MEM_W   = 2,
    parameter int EX_W    = 4
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    input  logic                      Flush,
    input  logic [REG_W-1:0]          Rs_ID,
    input  logic [REG_W-1:0]          Rt_ID,
    input  logic [REG_W-1:0]          Rd_ID,
    input  logic [SHAMT_W-1:0]        Shamt_ID,
    input  logic [FUNCT_W-1:0]        Funct_ID,
    input  logic [EX_W+MEM_W+WB_W-1:0] Ctrl_ID,
    input  logic [DATA_W-1:0]         RD1_ID,
    input  logic [DATA_W-1:0]         RD2_ID,
    input  logic [DATA_W-1:0]         Ext_Immed_ID,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic [WB_W-1:0]           WB_EX,
    output logic [MEM_W-1:0]          MEM_EX,
    output logic [EX_W-1:0]           EX_EX,
    output logic [REG_W-1:0]          Rs_EX,
    output logic [REG_W-1:0]          Rt_EX,
    output logic [REG_W-1:0]          Rd_EX,
    output logic [SHAMT_W-1:0]        Shamt_EX,
    output logic [FUNCT_W-1:0]        Funct_EX,
    output logic [DATA_W-1:0]         RD1_EX,
    output logic [DATA_W-1:0]         RD2_EX,
    output logic [DATA_W-1:0]         Ext_Immed_EX
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          Stall_Cnt,
    output logic [CNT_W-1:0]          Flush_Cnt
`endif
);

    localparam int CTRL_W = EX_W + MEM_W + WB_W;
    localparam int PAY_W  = 3*REG_W + SHAMT_W + FUNCT_W + 3*DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               accept_s;
    logic               consume_s;
    logic               load_main_in_s;
    logic               load_main_skid_s;
    logic               load_skid_s;
    logic [PAY_W-1:0]   in_pay_s;
    logic [PAY_W-1:0]   main_pay_r;
    logic [PAY_W-1:0]   skid_pay_r;
    logic [CTRL_W-1:0]  main_ctrl_r;
    logic [CTRL_W-1:0]  skid_ctrl_r;

    assign in_pay_s  = {Rs_ID, Rt_ID, Rd_ID, Shamt_ID, Funct_ID,
                        RD1_ID, RD2_ID, Ext_Immed_ID};
    assign accept_s  = In_Valid & in_ready_r;
    assign consume_s = out_valid_r & Out_Ready;

    // Next-state and entry-movement decode; Flush overrides every transfer.
    always_comb begin
        state_next_s     = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (Flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_next_s   = ST_MAIN;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_next_s   = ST_EMPTY;
                    end
                end
                ST_MAIN: begin
                    if (accept_s && !consume_s) begin
                        state_next_s = ST_SKID;
                        load_skid_s  = 1'b1;
                    end else if (accept_s && consume_s) begin
                        state_next_s   = ST_MAIN;
                        load_main_in_s = 1'b1;
                    end else if (consume_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_MAIN;
                    end
                end
                ST_SKID: begin
                    // In_Ready is low here, so no new entry can arrive.
                    if (consume_s) begin
                        state_next_s     = ST_MAIN;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_next_s     = ST_SKID;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State plus registered handshake flags, derived from the next state so
    // In_Ready never sees Out_Ready combinationally.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_SKID);
            out_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Output-entry payload; holds its last value when the register empties.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            main_pay_r <= '0;
        end else if (load_main_in_s) begin
            main_pay_r <= in_pay_s;
        end else if (load_main_skid_s) begin
            main_pay_r <= skid_pay_r;
        end else begin
            main_pay_r <= main_pay_r;
        end
    end

    // Output-entry control word; cleared whenever no valid entry remains
    // so EX sees a bubble.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            main_ctrl_r <= '0;
        end else if (state_next_s == ST_EMPTY) begin
            main_ctrl_r <= '0;
        end else if (load_main_in_s) begin
            main_ctrl_r <= Ctrl_ID;
        end else if (load_main_skid_s) begin
            main_ctrl_r <= skid_ctrl_r;
        end else begin
            main_ctrl_r <= main_ctrl_r;
        end
    end

    // Skid entry, captured only when the output entry is stalled.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            skid_pay_r  <= '0;
            skid_ctrl_r <= '0;
        end else if (load_skid_s) begin
            skid_pay_r  <= in_pay_s;
            skid_ctrl_r <= Ctrl_ID;
        end else begin
            skid_pay_r  <= skid_pay_r;
            skid_ctrl_r <= skid_ctrl_r;
        end
    end

    assign In_Ready  = in_ready_r;
    assign Out_Valid = out_valid_r;
    assign WB_EX     = main_ctrl_r[WB_W-1:0];
    assign MEM_EX    = main_ctrl_r[WB_W+MEM_W-1:WB_W];
    assign EX_EX     = main_ctrl_r[CTRL_W-1:WB_W+MEM_W];
    assign {Rs_EX, Rt_EX, Rd_EX, Shamt_EX, Funct_EX,
            RD1_EX, RD2_EX, Ext_Immed_EX} = main_pay_r;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating count of cycles where EX stalls a valid entry.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_cnt_r <= '0;
        end else if (out_valid_r && !Out_Ready && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating count of flushes that actually squash a held entry.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            flush_cnt_r <= '0;
        end else if (Flush && (state_r != ST_EMPTY) && (flush_cnt_r != '1)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign Stall_Cnt = stall_cnt_r;
    assign Flush_Cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_elastic_reg
//   Directed self-checking bench for id_ex_elastic_reg: reset, streaming,
//   back-pressure through the skid entry, flush, bubble and control split.
//   Perf counters are exercised when PIPE_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_id_ex_elastic_reg;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        In_Valid;
    logic        In_Ready;
    logic        Flush;
    logic [4:0]  Rs_ID, Rt_ID, Rd_ID, Shamt_ID;
    logic [5:0]  Funct_ID;
    logic [7:0]  Ctrl_ID;
    logic [31:0] RD1_ID, RD2_ID, Ext_Immed_ID;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [1:0]  WB_EX, MEM_EX;
    logic [3:0]  EX_EX;
    logic [4:0]  Rs_EX, Rt_EX, Rd_EX, Shamt_EX;
    logic [5:0]  Funct_EX;
    logic [31:0] RD1_EX, RD2_EX, Ext_Immed_EX;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] Stall_Cnt, Flush_Cnt;
    logic [15:0] stall_base, flush_base;
`endif

    int check_cnt = 0;
    int err_cnt   = 0;

    id_ex_elastic_reg dut (
        .Clk(Clk), .Rst(Rst),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .Flush(Flush),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
        .Shamt_ID(Shamt_ID), .Funct_ID(Funct_ID), .Ctrl_ID(Ctrl_ID),
        .RD1_ID(RD1_ID), .RD2_ID(RD2_ID), .Ext_Immed_ID(Ext_Immed_ID),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .WB_EX(WB_EX), .MEM_EX(MEM_EX), .EX_EX(EX_EX),
        .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
        .Shamt_EX(Shamt_EX), .Funct_EX(Funct_EX),
        .RD1_EX(RD1_EX), .RD2_EX(RD2_EX), .Ext_Immed_EX(Ext_Immed_EX)
`ifdef PIPE_PERF_CNT_EN
        ,
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] rd1,
                         input logic [7:0] ctrl);
        In_Valid = vld;
        RD1_ID   = rd1;
        Ctrl_ID  = ctrl;
    endtask

    initial begin
        Rst = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
        Rs_ID = 5'd0; Rt_ID = 5'd0; Rd_ID = 5'd0; Shamt_ID = 5'd0;
        Funct_ID = 6'd0; RD2_ID = 32'd0; Ext_Immed_ID = 32'd0;
        drive(1'b1, 32'h55, 8'hFF);

        // Reset held two cycles with a valid input present.
        tick; tick;
        check("rst_out_valid", 64'(Out_Valid), 64'd0);
        check("rst_in_ready", 64'(In_Ready), 64'd0);
        check("rst_ctrl", 64'({EX_EX, MEM_EX, WB_EX}), 64'd0);
        check("rst_rd1", 64'(RD1_EX), 64'd0);
        check("rst_rs", 64'(Rs_EX), 64'd0);

        Rst = 1'b1;
        drive(1'b0, 32'h0, 8'h00);
        tick;
        check("rel_in_ready", 64'(In_Ready), 64'd1);
        check("rel_out_valid", 64'(Out_Valid), 64'd0);

        // Streaming with EX always ready.
        Out_Ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 8'(i));
            tick;
            check($sformatf("stream_valid_%0d", i), 64'(Out_Valid), 64'd1);
            check($sformatf("stream_rd1_%0d", i), 64'(RD1_EX), 64'(i));
            check($sformatf("stream_rdy_%0d", i), 64'(In_Ready), 64'd1);
        end
        drive(1'b0, 32'h0, 8'h00);
        tick;
        check("bubble_valid", 64'(Out_Valid), 64'd0);
        check("bubble_ctrl", 64'({EX_EX, MEM_EX, WB_EX}), 64'd0);
        check("bubble_rd1_hold", 64'(RD1_EX), 64'd8);

        // Control split and field placement.
        Rs_ID = 5'd3; Rt_ID = 5'd5; Rd_ID = 5'd7; Shamt_ID = 5'd9;
        Funct_ID = 6'h2A; RD2_ID = 32'h1234; Ext_Immed_ID = 32'hFFFF_0001;
        drive(1'b1, 32'h77, 8'b1011_01_10);
        tick;
        check("split_ex", 64'(EX_EX), 64'b1011);
        check("split_mem", 64'(MEM_EX), 64'b01);
        check("split_wb", 64'(WB_EX), 64'b10);
        check("fields", 64'({Rs_EX, Rt_EX, Rd_EX, Shamt_EX, Funct_EX}),
              64'({5'd3, 5'd5, 5'd7, 5'd9, 6'h2A}));
        check("rd2", 64'(RD2_EX), 64'h1234);
        check("imm", 64'(Ext_Immed_EX), 64'hFFFF_0001);
        drive(1'b0, 32'h0, 8'h00);
        tick;

        // Back-pressure: A then B, C offered while full must be refused.
        Out_Ready = 1'b0;
        drive(1'b1, 32'hA, 8'h0A);
        tick;
        check("bp_a_rd1", 64'(RD1_EX), 64'hA);
        check("bp_a_rdy", 64'(In_Ready), 64'd1);
        drive(1'b1, 32'hB, 8'h0B);
        tick;
        check("bp_skid_rdy", 64'(In_Ready), 64'd0);
        check("bp_skid_rd1", 64'(RD1_EX), 64'hA);
        check("bp_skid_ctrl", 64'({EX_EX, MEM_EX, WB_EX}), 64'h0A);
        drive(1'b1, 32'hC, 8'h0C);
        tick;
        check("bp_hold_rd1", 64'(RD1_EX), 64'hA);
        check("bp_hold_rdy", 64'(In_Ready), 64'd0);
        drive(1'b0, 32'h0, 8'h00);
        Out_Ready = 1'b1;
        tick;
        check("bp_b_rd1", 64'(RD1_EX), 64'hB);
        check("bp_b_ctrl", 64'({EX_EX, MEM_EX, WB_EX}), 64'h0B);
        check("bp_b_rdy", 64'(In_Ready), 64'd1);
        tick;
        check("bp_drain_valid", 64'(Out_Valid), 64'd0);
        check("bp_no_c", 64'(RD1_EX), 64'hB);

        // Flush while in the skid state with a valid incoming entry.
        Out_Ready = 1'b0;
        drive(1'b1, 32'hD, 8'h0D);
        tick;
        drive(1'b1, 32'hE, 8'h0E);
        tick;
        check("fl_pre_rdy", 64'(In_Ready), 64'd0);
        drive(1'b1, 32'hF, 8'hFF);
        Flush = 1'b1;
        tick;
        check("fl_valid", 64'(Out_Valid), 64'd0);
        check("fl_ctrl", 64'({EX_EX, MEM_EX, WB_EX}), 64'd0);
        check("fl_rdy", 64'(In_Ready), 64'd1);
        Flush = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        Out_Ready = 1'b1;
        tick;
        check("fl_after_valid", 64'(Out_Valid), 64'd0);
        check("fl_after_rd1", 64'(RD1_EX), 64'hD);
        drive(1'b1, 32'h42, 8'h21);
        tick;
        check("post_fl_valid", 64'(Out_Valid), 64'd1);
        check("post_fl_rd1", 64'(RD1_EX), 64'h42);

`ifdef PIPE_PERF_CNT_EN
        // Five stalled cycles, then a flush of the held entry.
        stall_base = Stall_Cnt;
        flush_base = Flush_Cnt;
        drive(1'b0, 32'h0, 8'h00);
        Out_Ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
        end
        Out_Ready = 1'b1;
        Flush = 1'b1;
        tick;
        Flush = 1'b0;
        check("stall_cnt", 64'(Stall_Cnt - stall_base), 64'd5);
        check("flush_cnt", 64'(Flush_Cnt - flush_base), 64'd1);
        tick;
        Rst = 1'b0;
        tick;
        check("cnt_rst", 64'({Stall_Cnt, Flush_Cnt}), 64'd0);
        Rst = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
